tcdm_bank_port: RTL and testbench
=================================

// Module: tcdm_bank_port
// PURPOSE
// - Slave-side adapter between one XBAR_TCDM slave port and one st_tcdm_bank_1024x32 macro.
// - Generates grant, read/store response valid and response ID, replacing the ad-hoc registers
//   in cgratop. One instance per TCDM bank; Num_Slaves instances inside TCDM.
// - Runs a post-reset zero-fill sequence so CGRA loads never return X.
// PARAMETERS
// - DEPTH     1024  words per bank
// - ADDR_W    10    word address width, = $clog2(DEPTH)
// - DATA_W    32    data width; multiple of 8
// - ID_W      16    request ID width (XBAR data_ID_o)
// - RESP_REG  0     0: response 1 cycle after grant; 1: extra output register, 2 cycles
// - INIT_ZERO 1     1: zero-fill all DEPTH words after reset; 0: ready right after reset
// PORTS
// - Clk         in   1         clock
// - Reset       in   1         asynchronous reset, active low
// - Req_I       in   1         request from XBAR slave port
// - Gnt_O       out  1         grant; transfer when Req_I & Gnt_O
// - Wen_I       in   1         1 = load, 0 = store
// - Addr_I      in   ADDR_W    word address
// - Wdata_I     in   DATA_W    store data
// - Be_I        in   DATA_W/8  byte enables, 1 = write byte
// - Id_I        in   ID_W      request ID
// - Rvalid_O    out  1         response valid (loads and stores)
// - Rdata_O     out  DATA_W    load data; 0 on store responses
// - Rid_O       out  ID_W      ID of the request being answered
// - Init_Done_O out  1         high once zero-fill complete
// - Mem_Csn_O   out  1         SRAM chip select, active low
// - Mem_Wen_O   out  1         SRAM write enable, 0 = write
// - Mem_A_O     out  ADDR_W    SRAM address
// - Mem_D_O     out  DATA_W    SRAM write data
// - Mem_Wmn_O   out  DATA_W    SRAM bit write mask, 1 = bit masked
// - Mem_Q_I     in   DATA_W    SRAM read data, valid 1 cycle after read access
// BEHAVIOUR
// - Reset values: Gnt_O=0, Rvalid_O=0, Rdata_O=0, Rid_O=0, Init_Done_O=0, Mem_Csn_O=1,
//   Mem_Wen_O=1, Mem_A_O=0, Mem_D_O=0, Mem_Wmn_O='1; FSM=INIT (INIT_ZERO=1) else READY.
// - FSM INIT: each cycle Mem_Csn_O=0, Mem_Wen_O=0, Mem_A_O=cnt, Mem_D_O=0, Mem_Wmn_O=0;
//   cnt 0..DEPTH-1; after cnt==DEPTH-1 -> READY. Exactly DEPTH write cycles. Gnt_O=0 throughout.
// - FSM READY: Gnt_O=1, Init_Done_O=1 (registered, from state only; no Req_I->Gnt_O path).
//   Stays READY until Reset; Reset asserted mid-INIT restarts fill from cnt=0.
// - Accept (Req_I&Gnt_O): SRAM driven combinationally same cycle: Mem_Csn_O=0, Mem_Wen_O=Wen_I,
//   Mem_A_O=Addr_I, Mem_D_O=Wdata_I, Mem_Wmn_O bit i = ~Be_I[i/8]. No accept: Mem_Csn_O=1.
// - Response: pipeline of {valid, is_load, ID}; accept in cycle N -> Rvalid_O=1, Rid_O=Id_I
//   in cycle N+1 (RESP_REG=0) or N+2 (RESP_REG=1). Rdata_O=Mem_Q_I (captured when RESP_REG=1)
//   for loads, 0 for stores. Rvalid_O high exactly one cycle per accepted request.
// - Throughput 1 request/cycle back-to-back; responses in order, no bubbles inserted.
// - Read-after-write same address in consecutive cycles returns new data (SRAM ordering).
// - Req_I while Gnt_O=0: ignored, no SRAM access, no response; XBAR holds the request.
// - Rdata_O/Rid_O hold last value while Rvalid_O=0.
// CONFIGURATION
// - Macro TCDM_BANK_STATS_EN defined: adds ports Stats_Clr_I in 1, Rd_Cnt_O out 32,
//   Wr_Cnt_O out 32. Counters +1 per accepted load/store, saturate at 32'hFFFFFFFF,
//   reset to 0, synchronous clear on Stats_Clr_I (clear wins over simultaneous increment).
//   Zero-fill writes not counted.
// - Undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - Reset release, INIT_ZERO=1, DEPTH=1024 -> Gnt_O=0 for 1024 cycles, 1024 SRAM writes
//   addr 0..1023 data 0, then Gnt_O=Init_Done_O=1; load addr 0x3FF returns 0.
// - Store 0xDEADBEEF addr 0x010 ID 0x0003, Be=4'hF; next cycle load 0x010 ID 0x0004
//   -> Rvalid at N+1 Rid=3 Rdata=0, at N+2 Rid=4 Rdata=0xDEADBEEF.
// - Store 0x11223344 Be=4'b0101 over 0xFFFFFFFF -> load returns 0xFF22FF44.
// - 64 back-to-back random loads, RESP_REG=1 -> 64 Rvalid pulses, each exactly 2 cycles
//   after grant, IDs in order, data matches scoreboard.
// - Reset asserted at INIT cnt=500 -> all outputs to reset values at once; fill restarts at 0,
//   full 1024 cycles before Gnt_O.
// - TCDM_BANK_STATS_EN: 3 loads + 2 stores -> Rd_Cnt_O=3, Wr_Cnt_O=2; Stats_Clr_I with
//   concurrent load -> both counters 0 next cycle.

Source files
------------

// File: rtl/tcdm_bank_port.sv
// TCDM bank slave port: grant, response pipeline and post-reset zero-fill.
// Optional access counters: define TCDM_BANK_STATS_EN.
module tcdm_bank_port #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 16,
  parameter int unsigned RESP_REG  = 0,
  parameter int unsigned INIT_ZERO = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Req_I,
  output logic                Gnt_O,
  input  logic                Wen_I,
  input  logic [ADDR_W-1:0]   Addr_I,
  input  logic [DATA_W-1:0]   Wdata_I,
  input  logic [DATA_W/8-1:0] Be_I,
  input  logic [ID_W-1:0]     Id_I,
  output logic                Rvalid_O,
  output logic [DATA_W-1:0]   Rdata_O,
  output logic [ID_W-1:0]     Rid_O,
  output logic                Init_Done_O,
  output logic                Mem_Csn_O,
  output logic                Mem_Wen_O,
  output logic [ADDR_W-1:0]   Mem_A_O,
  output logic [DATA_W-1:0]   Mem_D_O,
  output logic [DATA_W-1:0]   Mem_Wmn_O,
  input  logic [DATA_W-1:0]   Mem_Q_I
`ifdef TCDM_BANK_STATS_EN
  ,
  input  logic                Stats_Clr_I,
  output logic [31:0]         Rd_Cnt_O,
  output logic [31:0]         Wr_Cnt_O
`endif
);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;
  localparam logic [0:0] ST_RST   =
    (INIT_ZERO != 0) ? ST_INIT : ST_READY;
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);
  localparam int unsigned NB = DATA_W / 8;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              gnt_q, gnt_d;
  logic              acc;
  logic              fill;

  assign acc = Req_I & gnt_q;
  // Gate the fill with Reset so the SRAM idles while reset is held.
  assign fill = (state_q == ST_INIT) & Reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = ST_READY;
        cnt_d   = '0;
      end
    end
    gnt_d = (state_d == ST_READY);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  assign Gnt_O       = gnt_q;
  assign Init_Done_O = gnt_q;

  always_comb begin
    Mem_Csn_O = 1'b1;
    Mem_Wen_O = 1'b1;
    Mem_A_O   = '0;
    Mem_D_O   = '0;
    Mem_Wmn_O = '1;
    if (fill) begin
      Mem_Csn_O = 1'b0;
      Mem_Wen_O = 1'b0;
      Mem_A_O   = cnt_q;
      Mem_Wmn_O = '0;
    end else if (acc) begin
      Mem_Csn_O = 1'b0;
      Mem_Wen_O = Wen_I;
      Mem_A_O   = Addr_I;
      Mem_D_O   = Wdata_I;
      for (int b = 0; b < NB; b++) begin
        Mem_Wmn_O[b*8 +: 8] = {8{~Be_I[b]}};
      end
    end
  end

  logic            v1_q, v1_d;
  logic            ld1_q, ld1_d;
  logic [ID_W-1:0] id1_q, id1_d;
  logic [DATA_W-1:0] data1;

  always_comb begin
    v1_d  = acc;
    ld1_d = ld1_q;
    id1_d = id1_q;
    if (acc) begin
      ld1_d = Wen_I;
      id1_d = Id_I;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      v1_q  <= 1'b0;
      ld1_q <= 1'b0;
      id1_q <= '0;
    end else begin
      v1_q  <= v1_d;
      ld1_q <= ld1_d;
      id1_q <= id1_d;
    end
  end

  assign data1 = ld1_q ? Mem_Q_I : '0;

  if (RESP_REG != 0) begin : g_resp_reg
    logic              v2_q, v2_d;
    logic [ID_W-1:0]   id2_q, id2_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;

    always_comb begin
      v2_d  = v1_q;
      id2_d = id2_q;
      rd2_d = rd2_q;
      if (v1_q) begin
        id2_d = id1_q;
        rd2_d = data1;
      end
    end

    always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
        v2_q  <= 1'b0;
        id2_q <= '0;
        rd2_q <= '0;
      end else begin
        v2_q  <= v2_d;
        id2_q <= id2_d;
        rd2_q <= rd2_d;
      end
    end

    assign Rvalid_O = v2_q;
    assign Rid_O    = id2_q;
    assign Rdata_O  = rd2_q;
  end else begin : g_resp_comb
    // Keeps Rdata_O stable once the SRAM output moves on.
    logic [DATA_W-1:0] hold_q, hold_d;

    always_comb begin
      hold_d = hold_q;
      if (v1_q) hold_d = data1;
    end

    always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) hold_q <= '0;
      else        hold_q <= hold_d;
    end

    assign Rvalid_O = v1_q;
    assign Rid_O    = id1_q;
    assign Rdata_O  = v1_q ? data1 : hold_q;
  end

`ifdef TCDM_BANK_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (Stats_Clr_I) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
    end else if (acc) begin
      if (Wen_I && rd_cnt_q != '1)
        rd_cnt_d = rd_cnt_q + 32'd1;
      if (!Wen_I && wr_cnt_q != '1)
        wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign Rd_Cnt_O = rd_cnt_q;
  assign Wr_Cnt_O = wr_cnt_q;
`endif

endmodule

// File: tb/tb_tcdm_bank_port.sv
// Bench for tcdm_bank_port: one RESP_REG=0 and one RESP_REG=1 instance,
// each on its own SRAM model, driven with identical directed requests.
module tb_tcdm_bank_port;

  typedef struct {
    logic [15:0] id;
    logic [31:0] data;
    int          due;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0;
  logic wen = 1'b1;
  logic [9:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic [15:0] id = '0;

  logic        gnt[2], rv[2], idone[2];
  logic        csn[2], mwen[2];
  logic [31:0] rdata[2], md[2], wmn[2], mq[2];
  logic [15:0] rid[2];
  logic [9:0]  ma[2];
  logic [31:0] mem0[1024];
  logic [31:0] mem1[1024];
  logic [31:0] ref_mem[1024];

`ifdef TCDM_BANK_STATS_EN
  logic        clr = 1'b0;
  logic [31:0] rdc[2], wrc[2];
`endif

  resp_t sb[2][$];
  int    cyc = 0;
  int    n_assert = 0;
  int    n_fail = 0;
  bit    mon_en = 1'b0;
  logic [15:0] last_id;
  logic [31:0] last_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tcdm_bank_port #(.RESP_REG(0), .INIT_ZERO(1)) u0 (
    .Clk(clk), .Reset(rst_n), .Req_I(req), .Gnt_O(gnt[0]),
    .Wen_I(wen), .Addr_I(addr), .Wdata_I(wdata), .Be_I(be),
    .Id_I(id), .Rvalid_O(rv[0]), .Rdata_O(rdata[0]),
    .Rid_O(rid[0]), .Init_Done_O(idone[0]),
    .Mem_Csn_O(csn[0]), .Mem_Wen_O(mwen[0]), .Mem_A_O(ma[0]),
    .Mem_D_O(md[0]), .Mem_Wmn_O(wmn[0]), .Mem_Q_I(mq[0])
`ifdef TCDM_BANK_STATS_EN
    , .Stats_Clr_I(clr), .Rd_Cnt_O(rdc[0]), .Wr_Cnt_O(wrc[0])
`endif
  );

  tcdm_bank_port #(.RESP_REG(1), .INIT_ZERO(1)) u1 (
    .Clk(clk), .Reset(rst_n), .Req_I(req), .Gnt_O(gnt[1]),
    .Wen_I(wen), .Addr_I(addr), .Wdata_I(wdata), .Be_I(be),
    .Id_I(id), .Rvalid_O(rv[1]), .Rdata_O(rdata[1]),
    .Rid_O(rid[1]), .Init_Done_O(idone[1]),
    .Mem_Csn_O(csn[1]), .Mem_Wen_O(mwen[1]), .Mem_A_O(ma[1]),
    .Mem_D_O(md[1]), .Mem_Wmn_O(wmn[1]), .Mem_Q_I(mq[1])
`ifdef TCDM_BANK_STATS_EN
    , .Stats_Clr_I(clr), .Rd_Cnt_O(rdc[1]), .Wr_Cnt_O(wrc[1])
`endif
  );

  always @(posedge clk) begin
    if (!csn[0]) begin
      if (!mwen[0])
        mem0[ma[0]] <= (mem0[ma[0]] & wmn[0]) | (md[0] & ~wmn[0]);
      else
        mq[0] <= mem0[ma[0]];
    end
    if (!csn[1]) begin
      if (!mwen[1])
        mem1[ma[1]] <= (mem1[ma[1]] & wmn[1]) | (md[1] & ~wmn[1]);
      else
        mq[1] <= mem1[ma[1]];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon_step(input int k);
    resp_t e;
    if (sb[k].size() > 0 && sb[k][0].due == cyc) begin
      e = sb[k].pop_front();
      check($sformatf("rvalid%0d", k), 64'(rv[k]), 64'd1);
      check($sformatf("rid%0d", k), 64'(rid[k]), 64'(e.id));
      check($sformatf("rdata%0d", k), 64'(rdata[k]), 64'(e.data));
    end else begin
      check($sformatf("rvalid_idle%0d", k), 64'(rv[k]), 64'd0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_step(0);
      mon_step(1);
    end
  end

  task automatic tx(input logic ld, input logic [9:0] a,
                    input logic [31:0] wd, input logic [3:0] b,
                    input logic [15:0] i, input logic [31:0] exp);
    resp_t e;
    req = 1'b1; wen = ld; addr = a; wdata = wd; be = b; id = i;
    e.id = i;
    e.data = ld ? exp : 32'h0;
    e.due = cyc + 1;
    sb[0].push_back(e);
    e.due = cyc + 2;
    sb[1].push_back(e);
    last_id = i;
    last_data = e.data;
    if (!ld) begin
      for (int j = 0; j < 4; j++)
        if (b[j]) ref_mem[a][j*8 +: 8] = wd[j*8 +: 8];
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req = 1'b0; wen = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_gnt"}, 64'(gnt[k]), 64'd0);
      check({tag, "_rvalid"}, 64'(rv[k]), 64'd0);
      check({tag, "_rdata"}, 64'(rdata[k]), 64'd0);
      check({tag, "_rid"}, 64'(rid[k]), 64'd0);
      check({tag, "_idone"}, 64'(idone[k]), 64'd0);
      check({tag, "_csn"}, 64'(csn[k]), 64'd1);
      check({tag, "_wen"}, 64'(mwen[k]), 64'd1);
      check({tag, "_a"}, 64'(ma[k]), 64'd0);
      check({tag, "_d"}, 64'(md[k]), 64'd0);
      check({tag, "_wmn"}, 64'(wmn[k]), 64'hFFFF_FFFF);
    end
  endtask

  task automatic fill_watch(input string tag);
    int n;
    int bad;
    n = 0;
    bad = 0;
    #1;
    while (!(gnt[0] || gnt[1]) && n < 1100) begin
      for (int k = 0; k < 2; k++) begin
        if (csn[k] !== 1'b0 || mwen[k] !== 1'b0 ||
            ma[k] !== n[9:0] || md[k] !== 32'h0 ||
            wmn[k] !== 32'h0)
          bad++;
      end
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_len"}, 64'(n), 64'd1024);
    check({tag, "_bad"}, 64'(bad), 64'd0);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_gnt"}, 64'(gnt[k]), 64'd1);
      check({tag, "_idone"}, 64'(idone[k]), 64'd1);
    end
    for (int j = 0; j < 1024; j++) ref_mem[j] = 32'h0;
  endtask

  initial begin
    logic [9:0] a;
    #3;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    fill_watch("fill");
    @(negedge clk);
    mon_en = 1'b1;

    tx(1'b1, 10'h3FF, 32'h0, 4'h0, 16'h0001, 32'h0);
    idle(3);

    tx(1'b0, 10'h010, 32'hDEAD_BEEF, 4'hF, 16'h0003, 32'h0);
    tx(1'b1, 10'h010, 32'h0, 4'h0, 16'h0004, 32'hDEAD_BEEF);
    idle(3);

    tx(1'b0, 10'h020, 32'hFFFF_FFFF, 4'hF, 16'h0005, 32'h0);
    tx(1'b0, 10'h020, 32'h1122_3344, 4'b0101, 16'h0006, 32'h0);
    tx(1'b1, 10'h020, 32'h0, 4'h0, 16'h0007, 32'hFF22_FF44);
    idle(3);

    for (int i = 0; i < 8; i++)
      tx(1'b0, 10'(i * 97 + 5), $urandom, 4'hF, 16'(16'h100 + i), 32'h0);
    for (int i = 0; i < 64; i++) begin
      if (i % 2 == 1) a = 10'((i / 2 % 8) * 97 + 5);
      else a = 10'($urandom_range(0, 1023));
      tx(1'b1, a, 32'h0, 4'h0, 16'(16'h200 + i), ref_mem[a]);
    end
    idle(4);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("hold_rid%0d", k), 64'(rid[k]), 64'(last_id));
      check($sformatf("hold_rdata%0d", k), 64'(rdata[k]),
            64'(last_data));
    end

`ifdef TCDM_BANK_STATS_EN
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    tx(1'b1, 10'h010, 32'h0, 4'h0, 16'h0301, 32'hDEAD_BEEF);
    tx(1'b0, 10'h030, 32'hA5A5_5A5A, 4'hF, 16'h0302, 32'h0);
    tx(1'b1, 10'h030, 32'h0, 4'h0, 16'h0303, 32'hA5A5_5A5A);
    tx(1'b0, 10'h031, 32'h0BAD_F00D, 4'h3, 16'h0304, 32'h0);
    tx(1'b1, 10'h031, 32'h0, 4'h0, 16'h0305, 32'h0000_F00D);
    idle(1);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rd_cnt%0d", k), 64'(rdc[k]), 64'd3);
      check($sformatf("wr_cnt%0d", k), 64'(wrc[k]), 64'd2);
    end
    clr = 1'b1;
    tx(1'b1, 10'h030, 32'h0, 4'h0, 16'h0306, 32'hA5A5_5A5A);
    clr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("clr_rd%0d", k), 64'(rdc[k]), 64'd0);
      check($sformatf("clr_wr%0d", k), 64'(wrc[k]), 64'd0);
    end
    idle(3);
`endif

    mon_en = 1'b0;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    repeat (500) @(negedge clk);
    #1;
    check("mid_addr", 64'(ma[0]), 64'd500);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    sb[0].delete();
    sb[1].delete();
    @(negedge clk);
    rst_n = 1'b1;
    fill_watch("refill");
    @(negedge clk);
    mon_en = 1'b1;
    tx(1'b1, 10'h020, 32'h0, 4'h0, 16'h0400, 32'h0);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
